// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and digit-validity helper for the serial BCD subtractor.
package bcd_pkg;

  localparam int unsigned DIG_W   = 4;
  localparam int unsigned DIG_MAX = 9;
  localparam int unsigned RADIX   = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    CPL  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic digit_invalid(input logic [DIG_W-1:0] d);
    return d > DIG_W'(DIG_MAX);
  endfunction

endpackage

// File: rtl/bcd_sub_serial_if.sv
// Request/response bundle between a requester and the serial BCD subtractor.
interface bcd_sub_serial_if #(
  parameter int unsigned NDIG = 4
);
  localparam int unsigned W = 4 * NDIG;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         neg;
  logic         invalid;

  modport master (
    output start, a, b,
    input  busy, done, diff, neg, invalid
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, neg, invalid
  );

endinterface

// File: rtl/bcd_digit_sub.sv
// One BCD digit of subtraction with borrow: d = a_d - b_d - bin, wrapped into 0..9.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [DIG_W-1:0] a_d,
  input  logic [DIG_W-1:0] b_d,
  input  logic             bin,
  output logic [DIG_W-1:0] d,
  output logic             bout
);

  localparam int unsigned TW = DIG_W + 1;

  logic [TW-1:0] t;

  // Range of t is -10..9, so the top bit of a TW-bit result is the sign.
  always_comb begin
    t    = TW'(a_d) - TW'(b_d) - TW'(bin);
    bout = t[DIG_W];
    d    = bout ? DIG_W'(t + TW'(RADIX)) : t[DIG_W-1:0];
  end

endmodule

// File: rtl/bcd_sub_serial.sv
// Digit-serial BCD subtractor returning |a-b| and sign; a borrow-out after the
// magnitude pass triggers a second tens-complement pass over the result.
module bcd_sub_serial
  import bcd_pkg::*;
#(
  parameter int unsigned NDIG = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bcd_sub_serial_if.slave      bus
);

  localparam int unsigned W     = NDIG * DIG_W;
  localparam int unsigned IDX_W = $clog2(NDIG);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     res_q, res_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             borrow_q, borrow_d;
  logic             inv_q, inv_d;
  logic             start_prev_q, start_prev_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [W-1:0]     diff_q, diff_d;
  logic             neg_q, neg_d;
  logic             invalid_q, invalid_d;

  logic [DIG_W-1:0] op_a, op_b, dig;
  logic             dig_bout;
  logic [W-1:0]     res_shift;
  logic             any_inv;
  logic             start_edge;

  // Shared digit cell: SUB feeds operand LSDs, CPL feeds 0 - result LSD.
  bcd_digit_sub u_digit (
    .a_d  (op_a),
    .b_d  (op_b),
    .bin  (borrow_q),
    .d    (dig),
    .bout (dig_bout)
  );

  always_comb begin
    op_a = (state_q == CPL) ? '0 : a_q[DIG_W-1:0];
    op_b = (state_q == CPL) ? res_q[DIG_W-1:0] : b_q[DIG_W-1:0];
    // New digit enters at the MSD end so after NDIG shifts the result is in place.
    res_shift = {dig, res_q[W-1:DIG_W]};
  end

  always_comb begin
    any_inv = 1'b0;
    for (int i = 0; i < int'(NDIG); i++) begin
      any_inv = any_inv | digit_invalid(bus.a[i*DIG_W +: DIG_W])
                        | digit_invalid(bus.b[i*DIG_W +: DIG_W]);
    end
  end

  // A held start launches only one operation; start must drop before the next.
  assign start_edge = bus.start & ~start_prev_q;

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    idx_d        = idx_q;
    borrow_d     = borrow_q;
    inv_d        = inv_q;
    start_prev_d = bus.start;
    busy_d       = busy_q;
    done_d       = 1'b0;
    diff_d       = diff_q;
    neg_d        = neg_q;
    invalid_d    = invalid_q;

    unique case (state_q)
      IDLE: begin
        if (start_edge) begin
          a_d      = bus.a;
          b_d      = bus.b;
          res_d    = '0;
          idx_d    = '0;
          borrow_d = 1'b0;
          inv_d    = any_inv;
          busy_d   = 1'b1;
          state_d  = SUB;
        end
      end

      SUB: begin
        if (inv_q) begin
          state_d   = DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          diff_d    = '0;
          neg_d     = 1'b0;
          invalid_d = 1'b1;
        end else begin
          res_d    = res_shift;
          a_d      = a_q >> DIG_W;
          b_d      = b_q >> DIG_W;
          borrow_d = dig_bout;
          idx_d    = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (dig_bout) begin
              borrow_d = 1'b0;
              state_d  = CPL;
            end else begin
              state_d   = DONE;
              busy_d    = 1'b0;
              done_d    = 1'b1;
              diff_d    = res_shift;
              neg_d     = 1'b0;
              invalid_d = 1'b0;
            end
          end
        end
      end

      CPL: begin
        res_d    = res_shift;
        borrow_d = dig_bout;
        idx_d    = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          idx_d     = '0;
          state_d   = DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          diff_d    = res_shift;
          neg_d     = 1'b1;
          invalid_d = 1'b0;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      idx_q        <= '0;
      borrow_q     <= 1'b0;
      inv_q        <= 1'b0;
      start_prev_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      diff_q       <= '0;
      neg_q        <= 1'b0;
      invalid_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      res_q        <= res_d;
      idx_q        <= idx_d;
      borrow_q     <= borrow_d;
      inv_q        <= inv_d;
      start_prev_q <= start_prev_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      diff_q       <= diff_d;
      neg_q        <= neg_d;
      invalid_q    <= invalid_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.diff    = diff_q;
  assign bus.neg     = neg_q;
  assign bus.invalid = invalid_q;

endmodule
